// File: rtl/spi_byte_sequencer_pkg.sv
// spi_pkg: sequencer state encoding and counter sizing shared by the byte sequencer slice
package spi_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, ISSUE, XFER, GAP, HOLD} spi_seq_state_e;
  function automatic int CntW(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction
endpackage

// File: rtl/spi_byte_sequencer_if.sv
// spi_byte_sequencer_if: producer/consumer byte streams plus the SPI engine handshake
interface spi_byte_sequencer_if;
  logic       tx_valid_i;
  logic [7:0] tx_data_i;
  logic       tx_ready_o;
  logic       rx_valid_o;
  logic [7:0] rx_data_o;
  logic       rx_ready_i;
  logic       spi_start_o;
  logic [7:0] spi_byte_o;
  logic [7:0] spi_byte_i;
  logic       spi_next_i;
  logic       spi_cs_no;
  logic       busy_o;
  modport slave (
    input  tx_valid_i, tx_data_i, rx_ready_i, spi_byte_i, spi_next_i,
    output tx_ready_o, rx_valid_o, rx_data_o, spi_start_o, spi_byte_o, spi_cs_no, busy_o
  );
  modport master (
    output tx_valid_i, tx_data_i, rx_ready_i, spi_byte_i, spi_next_i,
    input  tx_ready_o, rx_valid_o, rx_data_o, spi_start_o, spi_byte_o, spi_cs_no, busy_o
  );
endinterface

// File: rtl/spi_byte_fifo.sv
// spi_byte_fifo: synchronous first-word fall-through FIFO; head reads as zero when empty
module spi_byte_fifo #(
  parameter int Width = 8,
  parameter int Depth = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(Depth);
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [Width-1:0] mem [Depth];
  assign empty_o = wr_ptr == rd_ptr;
  assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata_o = empty_o ? '0 : mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + (AW+1)'(push_i);
      rd_ptr <= rd_ptr + (AW+1)'(pop_i);
    end
  always_ff @(posedge clk_i)
    if (push_i) mem[wr_ptr[AW-1:0]] <= wdata_i;
endmodule

// File: rtl/spi_byte_sequencer.sv
// spi_byte_sequencer: queues producer bytes, issues them to the SPI engine and frames CS around bursts
module spi_byte_sequencer
  import spi_pkg::*;
#(
  parameter int FifoDepth     = 8,
  parameter int CsSetupCycles = 4,
  parameter int CsHoldCycles  = 4
) (
  input logic clk_i,
  input logic rst_i,
  spi_byte_sequencer_if.slave bus
);
  localparam int CW = CntW(CsSetupCycles > CsHoldCycles ? CsSetupCycles : CsHoldCycles);
  // SETUP plus the single ISSUE cycle together span CsSetupCycles
  localparam logic [CW-1:0] SetupLast = CW'(CsSetupCycles - 1);
  localparam logic [CW-1:0] HoldLast  = CW'(CsHoldCycles);
  spi_seq_state_e state;
  logic [CW-1:0]  cnt;
  logic           cs_n, start, next_q;
  logic           tx_full, tx_empty, rx_full, rx_empty, xfer_done;
  logic [7:0]     tx_head, rx_head;
  assign xfer_done       = state == XFER && bus.spi_next_i && !next_q;
  assign bus.tx_ready_o  = !tx_full;
  assign bus.rx_valid_o  = !rx_empty;
  assign bus.rx_data_o   = rx_head;
  assign bus.spi_byte_o  = tx_head;
  assign bus.spi_start_o = start;
  assign bus.spi_cs_no   = cs_n;
  assign bus.busy_o      = state != IDLE;
  spi_byte_fifo #(.Width(8), .Depth(FifoDepth)) u_tx (
    .clk_i(clk_i), .rst_i(rst_i), .push_i(bus.tx_valid_i && !tx_full), .wdata_i(bus.tx_data_i),
    .pop_i(xfer_done), .rdata_o(tx_head), .full_o(tx_full), .empty_o(tx_empty)
  );
  spi_byte_fifo #(.Width(8), .Depth(FifoDepth)) u_rx (
    .clk_i(clk_i), .rst_i(rst_i), .push_i(xfer_done), .wdata_i(bus.spi_byte_i),
    .pop_i(bus.rx_ready_i && !rx_empty), .rdata_o(rx_head), .full_o(rx_full), .empty_o(rx_empty)
  );
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state  <= IDLE;
      cnt    <= '0;
      cs_n   <= 1'b1;
      start  <= 1'b0;
      next_q <= 1'b0;
    end else begin
      next_q <= bus.spi_next_i;
      case (state)
        IDLE:  if (!tx_empty) begin
                 state <= SETUP;
                 cs_n  <= 1'b0;
                 cnt   <= CW'(1);
               end
        SETUP: if (cnt >= SetupLast) state <= ISSUE;
               else cnt <= cnt + 1'b1;
        ISSUE: if (!rx_full) begin
                 state <= XFER;
                 start <= 1'b1;
               end
        XFER:  if (xfer_done) begin
                 state <= GAP;
                 start <= 1'b0;
               end
        GAP:   if (!bus.spi_next_i) begin
                 state <= tx_empty ? HOLD : ISSUE;
                 cnt   <= CW'(1);
               end
        HOLD:  if (!tx_empty) state <= ISSUE;
               else if (cnt >= HoldLast) begin
                 state <= IDLE;
                 cs_n  <= 1'b1;
               end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_spi_byte_sequencer.sv
// tb_spi_byte_sequencer: directed scenarios against a cycle-level SPI engine model
module tb_spi_byte_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  spi_byte_sequencer_if b ();
  spi_byte_sequencer #(.FifoDepth(8), .CsSetupCycles(4), .CsHoldCycles(4)) dut (
    .clk_i(clk), .rst_i(rst), .bus(b)
  );
  int total = 0, bad = 0;
  int cs_rise = 0, start_rise = 0, eng_cnt = 0;
  logic cs_prev = 1'b1, st_prev = 1'b0;
  logic eng_en = 1'b1, loopback = 1'b1;
  logic [7:0] resp = '0, fixed_resp = 8'h3C;
  // engine: accepts start, raises next two cycles later for three cycles, then idles
  initial begin
    b.spi_next_i = 1'b0;
    b.spi_byte_i = '0;
    forever begin
      @(posedge clk); #2;
      if (rst) begin
        eng_cnt = 0;
        b.spi_next_i = 1'b0;
      end else if (eng_cnt > 0) begin
        eng_cnt++;
        if (eng_cnt == 3) begin b.spi_byte_i = resp; b.spi_next_i = 1'b1; end
        if (eng_cnt == 6) b.spi_next_i = 1'b0;
        if (eng_cnt == 7) eng_cnt = 0;
      end else if (eng_en && b.spi_start_o) begin
        eng_cnt = 1;
        resp = loopback ? b.spi_byte_o : fixed_resp;
      end
    end
  end
  initial forever begin
    @(posedge clk); #3;
    if (b.spi_cs_no && !cs_prev) cs_rise++;
    if (b.spi_start_o && !st_prev) start_rise++;
    cs_prev = b.spi_cs_no;
    st_prev = b.spi_start_o;
  end
  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #4; end
  endtask
  task automatic push_byte(input logic [7:0] d);
    int g = 0;
    while (!b.tx_ready_o && g < 200) begin step(); g++; end
    b.tx_valid_i = 1'b1;
    b.tx_data_i  = d;
    step();
    b.tx_valid_i = 1'b0;
  endtask
  task automatic pop_byte(output logic [7:0] d, output logic ok);
    int g = 0;
    while (!b.rx_valid_o && g < 200) begin step(); g++; end
    ok = b.rx_valid_o;
    d  = b.rx_data_o;
    b.rx_ready_i = 1'b1;
    step();
    b.rx_ready_i = 1'b0;
  endtask
  task automatic wait_idle();
    int g = 0;
    while (b.busy_o && g < 600) begin step(); g++; end
  endtask
  task automatic test_reset();
    step(2);
    total++; if (b.spi_cs_no !== 1'b1) begin bad++; $display("FAIL rst_cs got %b want 1", b.spi_cs_no); end
    total++; if (b.spi_start_o !== 1'b0) begin bad++; $display("FAIL rst_start got %b want 0", b.spi_start_o); end
    total++; if (b.busy_o !== 1'b0) begin bad++; $display("FAIL rst_busy got %b want 0", b.busy_o); end
    total++; if (b.tx_ready_o !== 1'b1) begin bad++; $display("FAIL rst_tx_ready got %b want 1", b.tx_ready_o); end
    total++; if (b.rx_valid_o !== 1'b0) begin bad++; $display("FAIL rst_rx_valid got %b want 0", b.rx_valid_o); end
    total++; if (b.spi_byte_o !== 8'h00) begin bad++; $display("FAIL rst_spi_byte got %h want 00", b.spi_byte_o); end
    total++; if (b.rx_data_o !== 8'h00) begin bad++; $display("FAIL rst_rx_data got %h want 00", b.rx_data_o); end
    rst = 1'b0;
    step();
  endtask
  task automatic test_single();
    int k, g;
    logic [7:0] d;
    logic ok;
    loopback = 1'b0;
    push_byte(8'hA5);
    total++; if (b.spi_cs_no !== 1'b1) begin bad++; $display("FAIL single_cs_t1 got %b want 1", b.spi_cs_no); end
    step();
    total++; if (b.spi_cs_no !== 1'b0) begin bad++; $display("FAIL single_cs_t2 got %b want 0", b.spi_cs_no); end
    k = 2;
    while (!b.spi_start_o && k < 30) begin step(); k++; end
    total++; if (k != 6) begin bad++; $display("FAIL single_start_delay got %0d want 6", k); end
    total++; if (b.spi_byte_o !== 8'hA5) begin bad++; $display("FAIL single_spi_byte got %h want a5", b.spi_byte_o); end
    g = 0;
    while (b.spi_start_o && g < 30) begin step(); g++; end
    total++; if (g != 3) begin bad++; $display("FAIL single_start_len got %0d want 3", g); end
    total++; if (b.rx_valid_o !== 1'b1 || b.rx_data_o !== 8'h3C) begin bad++; $display("FAIL single_rx got v=%b d=%h want v=1 d=3c", b.rx_valid_o, b.rx_data_o); end
    g = 0;
    while (b.spi_next_i && g < 30) begin step(); g++; end
    k = 0;
    while (!b.spi_cs_no && k < 30) begin step(); k++; end
    total++; if (k != 5) begin bad++; $display("FAIL single_cs_hold got %0d want 5", k); end
    total++; if (b.busy_o !== 1'b0) begin bad++; $display("FAIL single_idle got %b want 0", b.busy_o); end
    pop_byte(d, ok);
    total++; if (!ok || d !== 8'h3C) begin bad++; $display("FAIL single_pop got ok=%b d=%h want ok=1 d=3c", ok, d); end
    total++; if (b.rx_valid_o !== 1'b0) begin bad++; $display("FAIL single_rx_empty got %b want 0", b.rx_valid_o); end
    loopback = 1'b1;
  endtask
  task automatic test_burst();
    logic [7:0] d;
    logic ok;
    cs_rise = 0;
    start_rise = 0;
    for (int i = 0; i < 4; i++) push_byte(8'(i + 1));
    wait_idle();
    total++; if (b.busy_o !== 1'b0) begin bad++; $display("FAIL burst_idle got %b want 0", b.busy_o); end
    total++; if (start_rise != 4) begin bad++; $display("FAIL burst_starts got %0d want 4", start_rise); end
    total++; if (cs_rise != 1) begin bad++; $display("FAIL burst_cs_rises got %0d want 1", cs_rise); end
    for (int i = 0; i < 4; i++) begin
      pop_byte(d, ok);
      total++; if (!ok || d !== 8'(i + 1)) begin bad++; $display("FAIL burst_rx%0d got ok=%b d=%h want ok=1 d=%h", i, ok, d, 8'(i + 1)); end
    end
  endtask
  task automatic test_tx_full();
    logic [7:0] d;
    logic ok;
    eng_en = 1'b0;
    for (int i = 0; i < 9; i++) begin
      b.tx_valid_i = 1'b1;
      b.tx_data_i  = 8'(8'h10 + i);
      step();
      b.tx_valid_i = 1'b0;
      total++; if (b.tx_ready_o !== (i < 7)) begin bad++; $display("FAIL txfull_ready%0d got %b want %b", i, b.tx_ready_o, i < 7); end
    end
    eng_en = 1'b1;
    wait_idle();
    total++; if (b.busy_o !== 1'b0) begin bad++; $display("FAIL txfull_idle got %b want 0", b.busy_o); end
    for (int i = 0; i < 8; i++) begin
      pop_byte(d, ok);
      total++; if (!ok || d !== 8'(8'h10 + i)) begin bad++; $display("FAIL txfull_rx%0d got ok=%b d=%h want ok=1 d=%h", i, ok, d, 8'(8'h10 + i)); end
    end
    total++; if (b.rx_valid_o !== 1'b0) begin bad++; $display("FAIL txfull_ninth_dropped got rx_valid=%b want 0", b.rx_valid_o); end
  endtask
  task automatic test_rx_backpressure();
    logic [7:0] d;
    logic ok;
    start_rise = 0;
    for (int i = 0; i < 10; i++) push_byte(8'(8'h20 + i));
    step(120);
    total++; if (start_rise != 8) begin bad++; $display("FAIL rxbp_starts got %0d want 8", start_rise); end
    total++; if (b.spi_cs_no !== 1'b0 || b.busy_o !== 1'b1 || b.spi_start_o !== 1'b0) begin bad++; $display("FAIL rxbp_stall got cs=%b busy=%b start=%b want 0 1 0", b.spi_cs_no, b.busy_o, b.spi_start_o); end
    total++; if (b.spi_byte_o !== 8'h28) begin bad++; $display("FAIL rxbp_head got %h want 28", b.spi_byte_o); end
    for (int i = 0; i < 10; i++) begin
      pop_byte(d, ok);
      total++; if (!ok || d !== 8'(8'h20 + i)) begin bad++; $display("FAIL rxbp_rx%0d got ok=%b d=%h want ok=1 d=%h", i, ok, d, 8'(8'h20 + i)); end
    end
    wait_idle();
    total++; if (start_rise != 10 || b.busy_o !== 1'b0) begin bad++; $display("FAIL rxbp_done got starts=%0d busy=%b want 10 0", start_rise, b.busy_o); end
  endtask
  task automatic test_hold_reentry();
    int g;
    logic [7:0] d;
    logic ok;
    cs_rise = 0;
    start_rise = 0;
    push_byte(8'h55);
    g = 0;
    while (!b.spi_start_o && g < 30) begin step(); g++; end
    g = 0;
    while (b.spi_start_o && g < 30) begin step(); g++; end
    g = 0;
    while (b.spi_next_i && g < 30) begin step(); g++; end
    step(2);
    push_byte(8'h66);
    total++; if (b.spi_cs_no !== 1'b0) begin bad++; $display("FAIL hold_cs_low got %b want 0", b.spi_cs_no); end
    step(2);
    total++; if (b.spi_start_o !== 1'b1 || b.spi_byte_o !== 8'h66) begin bad++; $display("FAIL hold_restart got start=%b byte=%h want 1 66", b.spi_start_o, b.spi_byte_o); end
    wait_idle();
    total++; if (cs_rise != 1 || start_rise != 2) begin bad++; $display("FAIL hold_frame got cs_rises=%0d starts=%0d want 1 2", cs_rise, start_rise); end
    pop_byte(d, ok);
    total++; if (!ok || d !== 8'h55) begin bad++; $display("FAIL hold_rx0 got ok=%b d=%h want ok=1 d=55", ok, d); end
    pop_byte(d, ok);
    total++; if (!ok || d !== 8'h66) begin bad++; $display("FAIL hold_rx1 got ok=%b d=%h want ok=1 d=66", ok, d); end
  endtask
  task automatic test_reset_mid();
    int g = 0;
    eng_en = 1'b0;
    push_byte(8'h99);
    while (!b.spi_start_o && g < 30) begin step(); g++; end
    total++; if (b.spi_start_o !== 1'b1) begin bad++; $display("FAIL midrst_in_xfer got %b want 1", b.spi_start_o); end
    rst = 1'b1;
    #1;
    total++; if (b.spi_cs_no !== 1'b1 || b.spi_start_o !== 1'b0) begin bad++; $display("FAIL midrst_immediate got cs=%b start=%b want 1 0", b.spi_cs_no, b.spi_start_o); end
    total++; if (b.busy_o !== 1'b0 || b.spi_byte_o !== 8'h00) begin bad++; $display("FAIL midrst_state got busy=%b byte=%h want 0 00", b.busy_o, b.spi_byte_o); end
    step();
    rst = 1'b0;
    eng_en = 1'b1;
    step(3);
    total++; if (b.busy_o !== 1'b0 || b.rx_valid_o !== 1'b0 || b.tx_ready_o !== 1'b1) begin bad++; $display("FAIL midrst_after got busy=%b rxv=%b txr=%b want 0 0 1", b.busy_o, b.rx_valid_o, b.tx_ready_o); end
  endtask
  initial begin
    b.tx_valid_i = 1'b0;
    b.tx_data_i  = '0;
    b.rx_ready_i = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_tx_full();
    test_rx_backpressure();
    test_hold_reentry();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
